// File: rtl/ethernet_frame_builder_pkg.sv
// Shared types and helpers for the Ethernet TX frame builder.
//   eth_tx_header_t  : one header descriptor (dst/src MAC, EtherType, 802.1Q tag)
//   builder_state_t  : frame builder FSM states
//   low_lane_mask()  : keep mask with the low n lanes set
//   header_bytes()   : wire-order header bytes, byte i in bits [8i+7:8i]
package ethernet_frame_builder_pkg;

  localparam int          ETH_HDR_BYTES  = 14;
  localparam int          VLAN_TAG_BYTES = 4;
  localparam logic [15:0] ETH_TPID_VLAN  = 16'h8100;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        vlan_present;
    logic [15:0] vlan_tci;
  } eth_tx_header_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_TAIL
  } builder_state_t;

  function automatic logic [7:0] low_lane_mask(input logic [3:0] n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Up to 18 header bytes. Untagged headers leave bytes 14..17 zero.
  function automatic logic [143:0] header_bytes(input eth_tx_header_t h,
                                                input logic [15:0] tpid);
    logic [143:0] b;
    b = '0;
    for (int i = 0; i < 6; i++) begin
      b[8*i +: 8]     = h.dst_mac[8*(5-i) +: 8];
      b[8*(6+i) +: 8] = h.src_mac[8*(5-i) +: 8];
    end
    if (h.vlan_present) begin
      b[96 +: 8]  = tpid[15:8];
      b[104 +: 8] = tpid[7:0];
      b[112 +: 8] = h.vlan_tci[15:8];
      b[120 +: 8] = h.vlan_tci[7:0];
      b[128 +: 8] = h.ethertype[15:8];
      b[136 +: 8] = h.ethertype[7:0];
    end else begin
      b[96 +: 8]  = h.ethertype[15:8];
      b[104 +: 8] = h.ethertype[7:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/ethernet_frame_builder_realigner.sv
// eth_byte_realigner: shifts payload bytes up by K lanes (K = 2 tagged,
// K = 6 untagged) behind the K header bytes still pending in the carry.
//   k_is_two              : 1 selects K = 2, 0 selects K = 6
//   load_en / load_carry  : preload carry with the trailing header bytes
//   shift_en              : payload beat accepted; carry takes its top K bytes
//   in_data / in_keep     : current payload beat
//   merged_*              : carry + payload beat, keep trimmed for a last beat
//   merged_fits           : last beat fits in one output beat (n + K <= 8)
//   tail_data / tail_keep : leftover carry beat after an overflowing last beat
module eth_byte_realigner
  import ethernet_frame_builder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        k_is_two,
  input  logic        load_en,
  input  logic [47:0] load_carry,
  input  logic        shift_en,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_keep,
  output logic [63:0] merged_data,
  output logic [7:0]  merged_keep,
  output logic        merged_fits,
  output logic [63:0] tail_data,
  output logic [7:0]  tail_keep
);

  logic [47:0] carry_reg;
  logic [47:0] carry_next;
  logic [2:0]  tail_cnt_reg;
  logic [3:0]  lane_sum;
  logic [63:0] raw_data;

  // Payload bytes plus pending header bytes on this beat (max 8 + 6).
  assign lane_sum    = 4'($countones(in_keep)) + (k_is_two ? 4'd2 : 4'd6);
  assign merged_fits = (lane_sum <= 4'd8);
  assign merged_keep = merged_fits ? low_lane_mask(lane_sum) : 8'hFF;
  assign tail_keep   = low_lane_mask({1'b0, tail_cnt_reg});
  assign carry_next  = k_is_two ? {32'd0, in_data[63:48]} : in_data[63:16];

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] lane_k2;
    logic [7:0] lane_k6;
    if (gi < 2) begin : g_k2_carry
      assign lane_k2 = carry_reg[8*gi +: 8];
    end else begin : g_k2_in
      assign lane_k2 = in_data[8*(gi-2) +: 8];
    end
    if (gi < 6) begin : g_k6_carry
      assign lane_k6 = carry_reg[8*gi +: 8];
      assign tail_data[8*gi +: 8] = tail_keep[gi] ? carry_reg[8*gi +: 8] : 8'h00;
    end else begin : g_k6_in
      assign lane_k6 = in_data[8*(gi-6) +: 8];
      // Tail never exceeds 6 bytes, so the top lanes are always empty.
      assign tail_data[8*gi +: 8] = 8'h00;
    end
    assign raw_data[8*gi +: 8]    = k_is_two ? lane_k2 : lane_k6;
    // Lanes past the last valid byte carry stale input bytes; zero them.
    assign merged_data[8*gi +: 8] = merged_keep[gi] ? raw_data[8*gi +: 8] : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_reg    <= '0;
      tail_cnt_reg <= '0;
    end else if (load_en) begin
      carry_reg <= load_carry;
    end else if (shift_en) begin
      carry_reg    <= carry_next;
      // Only meaningful when the last beat overflows (lane_sum > 8).
      tail_cnt_reg <= 3'(lane_sum - 4'd8);
    end
  end

endmodule

// File: rtl/ethernet_frame_builder.sv
// ethernet_frame_builder: prepends a 14/18-byte Ethernet header to a payload
// AXI-Stream and emits the wire-order frame on a 64-bit AXI-Stream.
//   s_hdr_*   : header descriptor (dst/src MAC, EtherType, optional VLAN TCI)
//   s_axis_*  : payload stream, byte n in bits [8n+7:8n]
//   m_axis_*  : registered frame stream, same lane order
module ethernet_frame_builder
  import ethernet_frame_builder_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter logic [15:0] VLAN_TPID  = ETH_TPID_VLAN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_hdr_valid,
  output logic                    s_hdr_ready,
  input  logic [47:0]             s_hdr_dst_mac,
  input  logic [47:0]             s_hdr_src_mac,
  input  logic [15:0]             s_hdr_ethertype,
  input  logic                    s_hdr_vlan_present,
  input  logic [15:0]             s_hdr_vlan_tci,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);

  if (DATA_WIDTH != 64) begin : g_width_check
    $error("ethernet_frame_builder supports DATA_WIDTH = 64 only");
  end

  builder_state_t state_reg;
  eth_tx_header_t hdr_reg;
  eth_tx_header_t hdr_in;
  eth_tx_header_t hdr_sel;
  logic           rdy_en_reg;
  logic [63:0]    m_data_reg;
  logic [7:0]     m_keep_reg;
  logic           m_valid_reg;
  logic           m_last_reg;

  logic [143:0] hdr_bytes;
  logic         adv;
  logic         hdr_hs;
  logic         pay_hs;
  logic         carry_load;
  logic [47:0]  carry_init;
  logic [63:0]  merged_data;
  logic [7:0]   merged_keep;
  logic         merged_fits;
  logic [63:0]  tail_data;
  logic [7:0]   tail_keep;

  assign m_axis_tdata  = m_data_reg;
  assign m_axis_tkeep  = m_keep_reg;
  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tlast  = m_last_reg;

  assign adv = m_axis_tready | ~m_valid_reg;

  // rdy_en_reg keeps both readies low while reset is asserted.
  assign s_hdr_ready   = rdy_en_reg & (state_reg == ST_IDLE) & adv;
  assign s_axis_tready = rdy_en_reg & (state_reg == ST_PAYLOAD) & adv;
  assign hdr_hs        = s_hdr_valid & s_hdr_ready;
  assign pay_hs        = s_axis_tvalid & s_axis_tready;

  assign hdr_in = '{dst_mac:      s_hdr_dst_mac,
                    src_mac:      s_hdr_src_mac,
                    ethertype:    s_hdr_ethertype,
                    vlan_present: s_hdr_vlan_present,
                    vlan_tci:     s_hdr_vlan_tci};

  // Beat 0 is formatted from the live descriptor at handshake; beat 1 and
  // the tagged carry come from the latched copy one cycle later.
  assign hdr_sel   = (state_reg == ST_IDLE) ? hdr_in : hdr_reg;
  assign hdr_bytes = header_bytes(hdr_sel, VLAN_TPID);

  // Carry is loaded on the cycle the FSM commits to PAYLOAD.
  assign carry_load = ((state_reg == ST_IDLE) & hdr_hs & ~s_hdr_vlan_present) |
                      ((state_reg == ST_HDR) & adv);
  assign carry_init = hdr_sel.vlan_present ? {32'd0, hdr_bytes[143:128]}
                                           : hdr_bytes[111:64];

  eth_byte_realigner u_realigner (
    .clk         (clk),
    .rst_n       (rst_n),
    .k_is_two    (hdr_reg.vlan_present),
    .load_en     (carry_load),
    .load_carry  (carry_init),
    .shift_en    (pay_hs),
    .in_data     (s_axis_tdata),
    .in_keep     (s_axis_tkeep),
    .merged_data (merged_data),
    .merged_keep (merged_keep),
    .merged_fits (merged_fits),
    .tail_data   (tail_data),
    .tail_keep   (tail_keep)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      hdr_reg     <= '0;
      rdy_en_reg  <= 1'b0;
      m_data_reg  <= '0;
      m_keep_reg  <= '0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
    end else begin
      rdy_en_reg <= 1'b1;
      // Output slot drained (or empty): clear it unless a new beat loads below.
      if (adv) begin
        m_data_reg  <= '0;
        m_keep_reg  <= '0;
        m_valid_reg <= 1'b0;
        m_last_reg  <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (hdr_hs) begin
            hdr_reg     <= hdr_in;
            m_data_reg  <= hdr_bytes[63:0];
            m_keep_reg  <= 8'hFF;
            m_valid_reg <= 1'b1;
            state_reg   <= s_hdr_vlan_present ? ST_HDR : ST_PAYLOAD;
          end
        end
        ST_HDR: begin
          if (adv) begin
            m_data_reg  <= hdr_bytes[127:64];
            m_keep_reg  <= 8'hFF;
            m_valid_reg <= 1'b1;
            state_reg   <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (pay_hs) begin
            m_data_reg  <= merged_data;
            m_valid_reg <= 1'b1;
            if (s_axis_tlast) begin
              m_keep_reg <= merged_keep;
              m_last_reg <= merged_fits;
              state_reg  <= merged_fits ? ST_IDLE : ST_TAIL;
            end else begin
              m_keep_reg <= 8'hFF;
            end
          end
        end
        ST_TAIL: begin
          if (adv) begin
            m_data_reg  <= tail_data;
            m_keep_reg  <= tail_keep;
            m_valid_reg <= 1'b1;
            m_last_reg  <= 1'b1;
            state_reg   <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
